// File: rtl/pong_pkg.sv
// pong_pkg: bounce codes, referee states and screen geometry.
// Shared by the collision detector and the ball FSM.
package pong_pkg;

  typedef enum logic [1:0] {
    BOUNCE_NONE   = 2'b00,
    BOUNCE_PADDLE = 2'b01,
    BOUNCE_WALL   = 2'b10,
    BOUNCE_SCORE  = 2'b11
  } bounce_e;

  typedef enum logic [1:0] {
    PLAY  = 2'b00,
    SERVE = 2'b01,
    OVER  = 2'b10
  } state_e;

  localparam int SCREEN_X  = 640;
  localparam int SCREEN_Y  = 480;
  // x values this far past the right edge are treated as wrapped negatives
  localparam int MISS_BAND = 128;

endpackage

// File: rtl/collision_detector_if.sv
// collision_detector_if: position inputs and referee outputs
// between the position registers, the detector and the ball FSM.
interface collision_detector_if;

  logic       frame_tick;
  logic       start;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [7:0] ball_w;
  logic [7:0] ball_h;
  logic [9:0] pad_l_y;
  logic [9:0] pad_r_y;
  logic [1:0] bounce;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       game_over;
  logic       winner;
  logic [7:0] rally_count;

  modport master (
    output frame_tick, start,
    output ball_x, ball_y, ball_w, ball_h,
    output pad_l_y, pad_r_y,
    input  bounce, score_l, score_r,
    input  game_over, winner, rally_count
  );

  modport slave (
    input  frame_tick, start,
    input  ball_x, ball_y, ball_w, ball_h,
    input  pad_l_y, pad_r_y,
    output bounce, score_l, score_r,
    output game_over, winner, rally_count
  );

endinterface

// File: rtl/aabb_overlap.sv
// aabb_overlap: 11-bit half-open rectangle intersection test.
// Empty rectangles never overlap anything.
module aabb_overlap (
  input  logic [10:0] a_x,
  input  logic [10:0] a_y,
  input  logic [10:0] a_w,
  input  logic [10:0] a_h,
  input  logic [10:0] b_x,
  input  logic [10:0] b_y,
  input  logic [10:0] b_w,
  input  logic [10:0] b_h,
  output logic        hit
);

  logic x_hit;
  logic y_hit;

  assign x_hit = (a_w != '0) && (b_w != '0)
              && (a_x < b_x + b_w) && (b_x < a_x + a_w);
  assign y_hit = (a_h != '0) && (b_h != '0)
              && (a_y < b_y + b_h) && (b_y < a_y + a_h);
  assign hit   = x_hit && y_hit;

endmodule

// File: rtl/collision_detector.sv
// collision_detector: per-frame Pong referee producing bounce codes and scores.
// Define COLLISION_RALLY_EN to build the rally_count paddle-hit counter.
module collision_detector #(
  parameter int SCREEN_X     = pong_pkg::SCREEN_X,
  parameter int SCREEN_Y     = pong_pkg::SCREEN_Y,
  parameter int PAD_L_X      = 16,
  parameter int PAD_R_X      = 616,
  parameter int PAD_W        = 8,
  parameter int PAD_H        = 64,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input logic                 clock,
  input logic                 reset,
  collision_detector_if.slave bus
);

  import pong_pkg::*;

  localparam logic [10:0] SX     = 11'(SCREEN_X);
  localparam logic [10:0] SY     = 11'(SCREEN_Y);
  localparam logic [10:0] SX_FAR = 11'(SCREEN_X + MISS_BAND);
  localparam logic [3:0]  WIN    = 4'(WIN_SCORE);
  localparam logic [7:0]  SRV_LD = 8'(SERVE_FRAMES);

  logic [10:0] bx, by, bw, bh;
  logic        hit_l, hit_r;
  logic        pad_hit, wall_hit;
  logic        miss_l, miss_r;

  state_e      state_q, state_d;
  bounce_e     bounce_q, bounce_d;
  logic [3:0]  sl_q, sl_d;
  logic [3:0]  sr_q, sr_d;
  logic        win_q, win_d;
  logic        pf_q, pf_d;
  logic        wf_q, wf_d;
  logic [7:0]  tmr_q, tmr_d;

  function automatic logic [3:0] sat_inc(
    input logic [3:0] s
  );
    return (s >= WIN) ? WIN : s + 4'd1;
  endfunction

  assign bx = {1'b0, bus.ball_x};
  assign by = {1'b0, bus.ball_y};
  assign bw = {3'b000, bus.ball_w};
  assign bh = {3'b000, bus.ball_h};

  aabb_overlap u_pad_l (
    .a_x (bx), .a_y (by), .a_w (bw), .a_h (bh),
    .b_x (11'(PAD_L_X)),
    .b_y ({1'b0, bus.pad_l_y}),
    .b_w (11'(PAD_W)),
    .b_h (11'(PAD_H)),
    .hit (hit_l)
  );

  aabb_overlap u_pad_r (
    .a_x (bx), .a_y (by), .a_w (bw), .a_h (bh),
    .b_x (11'(PAD_R_X)),
    .b_y ({1'b0, bus.pad_r_y}),
    .b_w (11'(PAD_W)),
    .b_h (11'(PAD_H)),
    .hit (hit_r)
  );

  assign pad_hit  = hit_l | hit_r;
  assign wall_hit = (by == '0) || (by + bh >= SY);
  assign miss_l   = (bx == '0) || (bx >= SX_FAR);
  assign miss_r   = (bx + bw >= SX) && (bx < SX_FAR);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= PLAY;
      bounce_q <= BOUNCE_NONE;
      sl_q     <= '0;
      sr_q     <= '0;
      win_q    <= 1'b0;
      pf_q     <= 1'b0;
      wf_q     <= 1'b0;
      tmr_q    <= '0;
    end else begin
      state_q  <= state_d;
      bounce_q <= bounce_d;
      sl_q     <= sl_d;
      sr_q     <= sr_d;
      win_q    <= win_d;
      pf_q     <= pf_d;
      wf_q     <= wf_d;
      tmr_q    <= tmr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bounce_d = BOUNCE_NONE;
    sl_d     = sl_q;
    sr_d     = sr_q;
    win_d    = win_q;
    pf_d     = pf_q;
    wf_d     = wf_q;
    tmr_d    = tmr_q;
    unique case (state_q)
      PLAY: if (bus.frame_tick) begin
        if (miss_l || miss_r) begin
          bounce_d = BOUNCE_SCORE;
          pf_d     = 1'b0;
          wf_d     = 1'b0;
          if (miss_l) sr_d = sat_inc(sr_q);
          else        sl_d = sat_inc(sl_q);
          if ((miss_l ? sr_d : sl_d) == WIN) begin
            state_d = OVER;
            win_d   = miss_l;
          end else begin
            state_d = SERVE;
            tmr_d   = SRV_LD;
          end
        end else begin
          if (pad_hit && !pf_q)
            bounce_d = BOUNCE_PADDLE;
          else if (wall_hit && !wf_q)
            bounce_d = BOUNCE_WALL;
          // a contact that lost arbitration keeps its flag low so it fires next tick
          pf_d = pad_hit && (pf_q || bounce_d == BOUNCE_PADDLE);
          wf_d = wall_hit && (wf_q || bounce_d == BOUNCE_WALL);
        end
      end
      SERVE: if (bus.frame_tick) begin
        tmr_d = tmr_q - 8'd1;
        if (tmr_q <= 8'd1) begin
          tmr_d   = '0;
          state_d = PLAY;
          pf_d    = 1'b0;
          wf_d    = 1'b0;
        end
      end
      OVER: if (bus.start) begin
        state_d = PLAY;
        sl_d    = '0;
        sr_d    = '0;
      end
      default: state_d = PLAY;
    endcase
  end

`ifdef COLLISION_RALLY_EN
  logic [7:0] rally_q;
  logic       rally_clr;
  logic       rally_inc;

  assign rally_clr = (state_d == SERVE && state_q != SERVE)
                  || (state_q == OVER && bus.start);
  assign rally_inc = (bounce_d == BOUNCE_PADDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      rally_q <= '0;
    else if (rally_clr)
      rally_q <= '0;
    else if (rally_inc && rally_q != 8'hFF)
      rally_q <= rally_q + 8'd1;
  end

  assign bus.rally_count = rally_q;
`else
  assign bus.rally_count = '0;
`endif

  assign bus.bounce    = bounce_q;
  assign bus.score_l   = sl_q;
  assign bus.score_r   = sr_q;
  assign bus.game_over = (state_q == OVER);
  assign bus.winner    = win_q;

endmodule

// File: tb/tb_collision_detector.sv
// tb_collision_detector: directed and random frames against a referee model.
// Define COLLISION_RALLY_EN to also exercise the rally counter.
module tb_collision_detector;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  collision_detector_if bus();

  collision_detector dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model: mode 0 play, 1 serve, 2 over
  int m_mode, m_bounce, m_sl, m_sr, m_winner, m_timer, m_rally;
  bit m_pf, m_wf;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit ovl(input int a, input int aw,
                             input int b, input int bw);
    int lo;
    int hi;
    lo = (a > b) ? a : b;
    hi = (a + aw < b + bw) ? a + aw : b + bw;
    return lo < hi;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_bounce = 0; m_sl = 0; m_sr = 0;
    m_winner = 0; m_timer = 0; m_rally = 0;
    m_pf = 0; m_wf = 0;
  endtask

  task automatic model_step(input bit tk, input bit st);
    int x, y, w, h, pl, pr;
    bit pad, wall, lm, rm;
    x = bus.ball_x; y = bus.ball_y;
    w = bus.ball_w; h = bus.ball_h;
    pl = bus.pad_l_y; pr = bus.pad_r_y;
    pad  = (ovl(x, w, 16, 8) && ovl(y, h, pl, 64))
        || (ovl(x, w, 616, 8) && ovl(y, h, pr, 64));
    wall = (y == 0) || (y + h >= 480);
    lm   = (x == 0) || (x >= 768);
    rm   = (x + w >= 640) && (x < 768);
    m_bounce = 0;
    if (m_mode == 2) begin
      if (st) begin
        m_mode = 0; m_sl = 0; m_sr = 0; m_rally = 0;
      end
    end else if (tk && m_mode == 1) begin
      m_timer--;
      if (m_timer == 0) begin
        m_mode = 0; m_pf = 0; m_wf = 0;
      end
    end else if (tk) begin
      if (lm || rm) begin
        m_bounce = 3; m_pf = 0; m_wf = 0;
        if (lm) m_sr = (m_sr < 9) ? m_sr + 1 : 9;
        else    m_sl = (m_sl < 9) ? m_sl + 1 : 9;
        if (m_sr == 9 || m_sl == 9) begin
          m_mode = 2; m_winner = lm;
        end else begin
          m_mode = 1; m_timer = 60; m_rally = 0;
        end
      end else begin
        if (pad && !m_pf) m_bounce = 1;
        else if (wall && !m_wf) m_bounce = 2;
        m_pf = pad && (m_pf || m_bounce == 1);
        m_wf = wall && (m_wf || m_bounce == 2);
        if (m_bounce == 1 && m_rally < 255) m_rally++;
      end
    end
  endtask

  task automatic check_outputs();
    check("bounce", bus.bounce, m_bounce);
    check("score_l", bus.score_l, m_sl);
    check("score_r", bus.score_r, m_sr);
    check("game_over", bus.game_over, (m_mode == 2) ? 1 : 0);
    if (m_mode == 2) check("winner", bus.winner, m_winner);
`ifdef COLLISION_RALLY_EN
    check("rally", bus.rally_count, m_rally);
`else
    check("rally", bus.rally_count, 0);
`endif
  endtask

  task automatic step(input int x, input int y, input int w, input int h,
                      input int pl, input int pr, input bit tk, input bit st);
    @(negedge clock);
    bus.ball_x = 10'(x); bus.ball_y = 10'(y);
    bus.ball_w = 8'(w);  bus.ball_h = 8'(h);
    bus.pad_l_y = 10'(pl); bus.pad_r_y = 10'(pr);
    bus.frame_tick = tk; bus.start = st;
    @(posedge clock);
    #1;
    model_step(tk, st);
    check_outputs();
  endtask

  task automatic tick(input int x, input int y, input int w, input int h,
                      input int pl, input int pr);
    step(x, y, w, h, pl, pr, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.frame_tick = 1'b0; bus.start = 1'b0;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int x, y, w, h, pl, pr;
    reset = 1'b1;
    bus.frame_tick = 1'b0; bus.start = 1'b0;
    bus.ball_x = '0; bus.ball_y = '0; bus.ball_w = '0; bus.ball_h = '0;
    bus.pad_l_y = '0; bus.pad_r_y = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_bounce", bus.bounce, 0);
    check("rst_score_l", bus.score_l, 0);
    check("rst_score_r", bus.score_r, 0);
    check("rst_game_over", bus.game_over, 0);
    check("rst_winner", bus.winner, 0);
    check("rst_rally", bus.rally_count, 0);
    @(negedge clock);
    reset = 1'b0;

    tick(100, 0, 8, 8, 200, 200);
    check("wall_first", bus.bounce, 2);
    step(100, 0, 8, 8, 200, 200, 1'b0, 1'b0);
    check("wall_pulse_end", bus.bounce, 0);
    tick(100, 0, 8, 8, 200, 200);
    check("wall_repeat", bus.bounce, 0);
    tick(300, 200, 8, 8, 200, 200);

    tick(20, 100, 8, 8, 90, 200);
    check("pad_hit", bus.bounce, 1);
    tick(300, 200, 8, 8, 200, 200);
    tick(20, 0, 8, 8, 0, 200);
    check("pad_over_wall", bus.bounce, 1);
    tick(20, 0, 8, 8, 0, 200);
    check("wall_deferred", bus.bounce, 2);

    tick(0, 200, 8, 8, 200, 200);
    check("miss_l_code", bus.bounce, 3);
    check("miss_l_score", bus.score_r, 1);
    repeat (60) tick(100, 0, 8, 8, 200, 200);
    check("serve_quiet", bus.bounce, 0);
    tick(100, 0, 8, 8, 200, 200);
    check("serve_end_wall", bus.bounce, 2);

    tick(0, 200, 8, 8, 200, 200);
    repeat (30) tick(300, 200, 8, 8, 200, 200);
    #2;
    reset = 1'b1;
    #1;
    check("srv_rst_score_r", bus.score_r, 0);
    check("srv_rst_bounce", bus.bounce, 0);
    check("srv_rst_over", bus.game_over, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    tick(100, 0, 8, 8, 200, 200);
    check("srv_rst_play", bus.bounce, 2);

    repeat (8) begin
      tick(635, 200, 8, 8, 200, 200);
      repeat (60) tick(300, 200, 8, 8, 200, 200);
    end
    check("score_l_8", bus.score_l, 8);
    tick(635, 200, 8, 8, 200, 200);
    check("win_code", bus.bounce, 3);
    check("win_score", bus.score_l, 9);
    check("win_over", bus.game_over, 1);
    check("win_winner", bus.winner, 0);
    tick(0, 200, 8, 8, 200, 200);
    check("over_ignored", bus.score_r, 0);
    step(100, 0, 8, 8, 200, 200, 1'b1, 1'b1);
    check("start_wins_code", bus.bounce, 0);
    check("start_score_l", bus.score_l, 0);
    check("start_over", bus.game_over, 0);
    tick(100, 0, 8, 8, 200, 200);
    check("after_start_wall", bus.bounce, 2);

    do_reset();
    for (int i = 0; i < 6000; i++) begin
      case ($urandom_range(0, 5))
        0: x = $urandom_range(0, 1023);
        1: x = $urandom_range(4, 28);
        2: x = $urandom_range(600, 628);
        3: x = $urandom_range(0, 1);
        4: x = $urandom_range(630, 800);
        default: x = $urandom_range(100, 500);
      endcase
      case ($urandom_range(0, 3))
        0: y = $urandom_range(0, 1023);
        1: y = $urandom_range(0, 2);
        2: y = $urandom_range(440, 479);
        default: y = $urandom_range(20, 400);
      endcase
      w = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                      : $urandom_range(0, 16);
      h = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                      : $urandom_range(0, 16);
      pl = $urandom_range(0, 460);
      pr = $urandom_range(0, 460);
      step(x, y, w, h, pl, pr,
           $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
    end

`ifdef COLLISION_RALLY_EN
    do_reset();
    repeat (300) begin
      tick(20, 100, 8, 8, 90, 200);
      tick(300, 200, 8, 8, 200, 200);
    end
    check("rally_sat", bus.rally_count, 255);
    tick(0, 200, 8, 8, 200, 200);
    check("rally_clear", bus.rally_count, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
